coin_acceptor: RTL and testbench

Front-end coin validator for the vending machine. It samples the raw coin-slot optical sensor and measures the high-pulse width of each coin passage in clock cycles. Each coin is classified as 5-rupee, 10-rupee or invalid. The block emits the single-cycle `five_rup` / `ten_rup` pulses that the vending FSMs consume, and a `coin_reject` pulse that drives the return flap.

---
 rtl/vend_pkg.sv | 53 +++++
 rtl/bit_sync.sv | 27 ++
 rtl/coin_acceptor.sv | 143 ++++++++++++++
 tb/tb_coin_acceptor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: accepter states, coin classes,
// default coin-width constants and the coin classification function.
package vend_pkg;

  typedef enum logic [2:0] {
    DISARM,
    IDLE,
    MEASURE,
    LOCKOUT,
    WAIT_LOW
  } acc_state_t;

  typedef enum logic [1:0] {
    NONE,
    C5,
    C10,
    REJ
  } coin_class_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int GLITCH_MAX_DEF  = 2;
  localparam int MIN_5_DEF       = 4;
  localparam int MAX_5_DEF       = 6;
  localparam int MIN_10_DEF      = 9;
  localparam int MAX_10_DEF      = 12;
  localparam int LOCKOUT_CYC_DEF = 8;

  // Glitches are dropped before accept_en is considered, so noise never
  // kicks the return flap even while the machine is not accepting coins.
  function automatic coin_class_t classify_coin(
    input int   width,
    input logic accept,
    input int   glitch_max,
    input int   min_5,
    input int   max_5,
    input int   min_10,
    input int   max_10
  );
    coin_class_t cls;
    if (width <= glitch_max)
      cls = NONE;
    else if (!accept)
      cls = REJ;
    else if ((width >= min_5) && (width <= max_5))
      cls = C5;
    else if ((width >= min_10) && (width <= max_10))
      cls = C10;
    else
      cls = REJ;
    return cls;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw bit through the flop chain; reset clears every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronizes the optical sensor, measures each
// high pulse, classifies it as 5 / 10 rupee / reject and enforces a
// lockout so a single coin is never counted twice.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int GLITCH_MAX  = GLITCH_MAX_DEF,
  parameter int MIN_5       = MIN_5_DEF,
  parameter int MAX_5       = MAX_5_DEF,
  parameter int MIN_10      = MIN_10_DEF,
  parameter int MAX_10      = MAX_10_DEF,
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin_sense,
  input  logic accept_en,
  output logic five_rup,
  output logic ten_rup,
  output logic coin_reject,
  output logic busy
);

  localparam int CW = $clog2(MAX_10 + 2);
  localparam int LW = (LOCKOUT_CYC < 1) ? 1 : $clog2(LOCKOUT_CYC + 1);
  localparam int AW = $clog2(SYNC_STAGES + 1);

  localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_10 + 1);
  localparam logic [LW-1:0] LOCK_VAL = LW'(LOCKOUT_CYC);
  localparam logic [AW-1:0] ARM_VAL  = AW'(SYNC_STAGES);

  logic            sense_s;
  acc_state_t      state;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   lock_cnt;
  logic [AW-1:0]   arm_cnt;
  logic            arm_done;
  coin_class_t     cls;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sense_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (coin_sense),
    .q    (sense_s)
  );

  // The synchronizer comes out of reset full of zeros; DISARM must not
  // trust sense_s until the chain has refilled, otherwise the tail of a
  // coin present at reset would look like a fresh rising edge.
  assign arm_done = (arm_cnt == ARM_VAL);

  // Classification of the measured width in the cycle the beam clears.
  always_comb begin
    cls = classify_coin(32'(cnt), accept_en, GLITCH_MAX, MIN_5, MAX_5, MIN_10, MAX_10);
  end

  // Main accepter FSM with registered coin pulses and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DISARM;
      cnt         <= '0;
      lock_cnt    <= '0;
      arm_cnt     <= '0;
      five_rup    <= 1'b0;
      ten_rup     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      five_rup    <= 1'b0;
      ten_rup     <= 1'b0;
      coin_reject <= 1'b0;

      if (!arm_done) begin
        arm_cnt <= arm_cnt + 1'b1;
      end

      case (state)
        DISARM: begin
          if (arm_done && !sense_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            busy  <= sense_s;
          end
        end

        IDLE: begin
          if (sense_s) begin
            cnt   <= CW'(1);
            state <= MEASURE;
            busy  <= 1'b1;
          end
        end

        MEASURE: begin
          if (sense_s) begin
            if (cnt != CNT_SAT) begin
              cnt <= cnt + 1'b1;
            end
          end else if (cls == NONE) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            five_rup    <= (cls == C5);
            ten_rup     <= (cls == C10);
            coin_reject <= (cls == REJ);
            lock_cnt    <= LOCK_VAL;
            state       <= LOCKOUT;
          end
        end

        LOCKOUT: begin
          if (lock_cnt == '0) begin
            if (sense_s) begin
              state <= WAIT_LOW;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

        WAIT_LOW: begin
          if (!sense_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= DISARM;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor. Each scenario drives a per-cycle
// waveform on coin_sense / accept_en / rst_n and inspects a cycle log.
module tb_coin_acceptor;

  localparam int LOGN = 64;

  logic clk;
  logic rst_n;
  logic coin_sense;
  logic accept_en;
  logic five_rup;
  logic ten_rup;
  logic coin_reject;
  logic busy;

  int errors;
  int checks;

  logic five_log [LOGN];
  logic ten_log  [LOGN];
  logic rej_log  [LOGN];
  logic busy_log [LOGN];
  int   cnt_log  [LOGN];

  coin_acceptor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_sense (coin_sense),
    .accept_en  (accept_en),
    .five_rup   (five_rup),
    .ten_rup    (ten_rup),
    .coin_reject(coin_reject),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample k is taken 1 ns after posedge k; inputs set right after it hold
  // for period k. Raw high in periods s..s+w-1 gives a pulse at sample
  // s+w+3 and busy low again at sample s+w+12.
  task automatic run_wave(input int s1, input int l1, input int s2, input int l2,
                          input int d1, input int dl, input int rs, input int ncyc);
    for (int k = 0; k < LOGN; k++) begin
      five_log[k] = 1'b0;
      ten_log[k]  = 1'b0;
      rej_log[k]  = 1'b0;
      busy_log[k] = 1'b0;
      cnt_log[k]  = 0;
    end
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      five_log[k] = five_rup;
      ten_log[k]  = ten_rup;
      rej_log[k]  = coin_reject;
      busy_log[k] = busy;
      cnt_log[k]  = int'(dut.cnt);
      coin_sense  = ((k >= s1) && (k < s1 + l1)) || ((s2 >= 0) && (k >= s2) && (k < s2 + l2));
      accept_en   = !((d1 >= 0) && (k >= d1) && (k < d1 + dl));
      rst_n       = !((rs >= 0) && (k == rs));
    end
    coin_sense = 1'b0;
    accept_en  = 1'b1;
    rst_n      = 1'b1;
  endtask

  function automatic int count_log(input int which);
    int n;
    n = 0;
    for (int k = 0; k < LOGN; k++) begin
      if (which == 0 && five_log[k] === 1'b1) n++;
      if (which == 1 && ten_log[k]  === 1'b1) n++;
      if (which == 2 && rej_log[k]  === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst_n      = 1'b1;
    coin_sense = 1'b0;
    accept_en  = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (five_rup !== 1'b0) begin errors++; $display("[TB] FAIL reset_five: got %b expected 0", five_rup); end
    checks++;
    if (ten_rup !== 1'b0) begin errors++; $display("[TB] FAIL reset_ten: got %b expected 0", ten_rup); end
    checks++;
    if (coin_reject !== 1'b0) begin errors++; $display("[TB] FAIL reset_reject: got %b expected 0", coin_reject); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_five();
    run_wave(0, 5, -1, 0, -1, 0, -1, 22);
    checks++;
    if (five_log[7] !== 1'b0) begin errors++; $display("[TB] FAIL five_early: got %b expected 0", five_log[7]); end
    checks++;
    if (five_log[8] !== 1'b1) begin errors++; $display("[TB] FAIL five_pulse: got %b expected 1", five_log[8]); end
    checks++;
    if (count_log(0) !== 1) begin errors++; $display("[TB] FAIL five_count: got %0d expected 1", count_log(0)); end
    checks++;
    if (count_log(1) + count_log(2) !== 0) begin errors++; $display("[TB] FAIL five_others: got %0d expected 0", count_log(1) + count_log(2)); end
    checks++;
    if (busy_log[3] !== 1'b1) begin errors++; $display("[TB] FAIL five_busy_rise: got %b expected 1", busy_log[3]); end
    checks++;
    if (busy_log[16] !== 1'b1) begin errors++; $display("[TB] FAIL five_busy_lock: got %b expected 1", busy_log[16]); end
    checks++;
    if (busy_log[17] !== 1'b0) begin errors++; $display("[TB] FAIL five_busy_fall: got %b expected 0", busy_log[17]); end
  endtask

  task automatic test_back_to_back();
    run_wave(0, 10, 14, 5, -1, 0, -1, 35);
    checks++;
    if (ten_log[13] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ten_pulse: got %b expected 1", ten_log[13]); end
    checks++;
    if (count_log(1) !== 1) begin errors++; $display("[TB] FAIL b2b_ten_count: got %0d expected 1", count_log(1)); end
    checks++;
    if (count_log(0) + count_log(2) !== 0) begin errors++; $display("[TB] FAIL b2b_ignored: got %0d expected 0", count_log(0) + count_log(2)); end
    checks++;
    if (busy_log[21] !== 1'b1 || busy_log[22] !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_busy: got %b%b expected 10", busy_log[21], busy_log[22]);
    end
  endtask

  task automatic test_widths();
    int widths [10] = '{2, 3, 4, 6, 7, 8, 9, 12, 13, 20};
    int exp_cls [10] = '{0, 4, 1, 1, 4, 4, 2, 2, 4, 4};
    int w;
    int got;
    int total;
    for (int i = 0; i < 10; i++) begin
      w = widths[i];
      run_wave(0, w, -1, 0, -1, 0, -1, w + 16);
      got   = {29'd0, rej_log[w+3], ten_log[w+3], five_log[w+3]};
      total = count_log(0) + count_log(1) + count_log(2);
      checks++;
      if (got !== exp_cls[i]) begin errors++; $display("[TB] FAIL width_%0d_class: got %0d expected %0d", w, got, exp_cls[i]); end
      checks++;
      if (total !== ((exp_cls[i] != 0) ? 1 : 0)) begin
        errors++; $display("[TB] FAIL width_%0d_total: got %0d expected %0d", w, total, (exp_cls[i] != 0) ? 1 : 0);
      end
      if (w == 2) begin
        checks++;
        if (busy_log[5] !== 1'b0) begin errors++; $display("[TB] FAIL glitch_no_lockout: got %b expected 0", busy_log[5]); end
      end
      if (w == 20) begin
        checks++;
        if (cnt_log[22] !== 13) begin errors++; $display("[TB] FAIL width_20_sat: got %0d expected 13", cnt_log[22]); end
      end
    end
  endtask

  task automatic test_accept_drop();
    run_wave(0, 5, -1, 0, 5, 10, -1, 22);
    checks++;
    if (rej_log[8] !== 1'b1) begin errors++; $display("[TB] FAIL drop_reject: got %b expected 1", rej_log[8]); end
    checks++;
    if (count_log(0) !== 0) begin errors++; $display("[TB] FAIL drop_no_five: got %0d expected 0", count_log(0)); end
    run_wave(0, 5, -1, 0, 3, 2, -1, 22);
    checks++;
    if (five_log[8] !== 1'b1 || count_log(2) !== 0) begin
      errors++; $display("[TB] FAIL drop_restored: got five=%b rej=%0d expected five=1 rej=0", five_log[8], count_log(2));
    end
  endtask

  task automatic test_long_hold();
    run_wave(0, 30, -1, 0, -1, 0, -1, 46);
    checks++;
    if (rej_log[33] !== 1'b1 || count_log(2) !== 1) begin
      errors++; $display("[TB] FAIL long_reject: got pulse=%b count=%0d expected pulse=1 count=1", rej_log[33], count_log(2));
    end
    checks++;
    if (cnt_log[20] !== 13) begin errors++; $display("[TB] FAIL long_sat: got %0d expected 13", cnt_log[20]); end
  endtask

  task automatic test_wait_low();
    run_wave(0, 5, 9, 15, -1, 0, -1, 40);
    checks++;
    if (five_log[8] !== 1'b1 || count_log(0) + count_log(1) + count_log(2) !== 1) begin
      errors++; $display("[TB] FAIL wl_single: got five=%b total=%0d expected five=1 total=1",
                         five_log[8], count_log(0) + count_log(1) + count_log(2));
    end
    checks++;
    if (busy_log[17] !== 1'b1 || busy_log[26] !== 1'b1) begin
      errors++; $display("[TB] FAIL wl_busy_hold: got %b%b expected 11", busy_log[17], busy_log[26]);
    end
    checks++;
    if (busy_log[27] !== 1'b0) begin errors++; $display("[TB] FAIL wl_busy_fall: got %b expected 0", busy_log[27]); end
    run_wave(0, 5, -1, 0, -1, 0, -1, 20);
    checks++;
    if (five_log[8] !== 1'b1) begin errors++; $display("[TB] FAIL wl_next_coin: got %b expected 1", five_log[8]); end
  endtask

  task automatic test_reset_midcoin();
    run_wave(0, 10, -1, 0, -1, 0, 5, 30);
    checks++;
    if (busy_log[5] !== 1'b1 || busy_log[6] !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_busy: got %b%b expected 10", busy_log[5], busy_log[6]);
    end
    checks++;
    if (count_log(0) + count_log(1) + count_log(2) !== 0) begin
      errors++; $display("[TB] FAIL mid_reset_pulse: got %0d expected 0", count_log(0) + count_log(1) + count_log(2));
    end
    checks++;
    if (busy_log[9] !== 1'b1 || busy_log[12] !== 1'b1 || busy_log[13] !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_disarm: got %b%b%b expected 110", busy_log[9], busy_log[12], busy_log[13]);
    end
    run_wave(0, 10, -1, 0, -1, 0, -1, 26);
    checks++;
    if (ten_log[13] !== 1'b1 || count_log(1) !== 1) begin
      errors++; $display("[TB] FAIL mid_reset_next_ten: got pulse=%b count=%0d expected pulse=1 count=1", ten_log[13], count_log(1));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_five();
    test_back_to_back();
    test_widths();
    test_accept_drop();
    test_long_hold();
    test_wait_low();
    test_reset_midcoin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
